// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// the bundle of pipeline control strobes the controller emits each cycle.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MULDIV = 2'd1,
        ST_FLUSH  = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic stall;
        logic flush;
        logic ex_hold;
    } strobes_t;

    localparam strobes_t STROBES_RUN = '{
        pc_write: 1'b1, if_id_write: 1'b1, stall: 1'b0, flush: 1'b0, ex_hold: 1'b0
    };
    localparam strobes_t STROBES_FREEZE = '{
        pc_write: 1'b0, if_id_write: 1'b0, stall: 1'b0, flush: 1'b0, ex_hold: 1'b1
    };
    localparam strobes_t STROBES_FLUSH = '{
        pc_write: 1'b1, if_id_write: 1'b1, stall: 1'b0, flush: 1'b1, ex_hold: 1'b0
    };
    localparam strobes_t STROBES_LOAD_USE = '{
        pc_write: 1'b0, if_id_write: 1'b0, stall: 1'b1, flush: 1'b0, ex_hold: 1'b0
    };

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: the load in ID/EX writes a register the
// instruction in IF/ID is about to read. x0 never creates a dependency.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    output logic                  hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_dest == id_rs);
    assign rt_match = id_uses_rt && (ex_dest == id_rt);
    assign hazard   = ex_mem_read && (ex_dest != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory wait, control-flow flush,
// multi-cycle mul/div hold and load-use stalls; counts stalled cycles.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_MAX_CYCLES = 64,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            inIdRs,
    input  logic [4:0]            inIdRt,
    input  logic                  inIdUsesRt,
    input  logic                  inExMemRead,
    input  logic [4:0]            inExDestRegister,
    input  logic                  inExBranchTaken,
    input  logic                  inExMulDivStart,
    input  logic                  inMulDivDone,
    input  logic                  inMemWait,
    output logic                  outPcWrite,
    output logic                  outIfIdWrite,
    output logic                  outStall,
    output logic                  outFlush,
    output logic                  outExHold,
    output logic                  outTimeout,
    output logic [1:0]            outState,
    output logic [CNT_WIDTH-1:0]  outStallCount
);

    localparam int unsigned        WD_WIDTH = $clog2(MULDIV_MAX_CYCLES + 1);
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(MULDIV_MAX_CYCLES - 1);

    ctrl_state_e          state_q, state_d;
    logic [WD_WIDTH-1:0]  wd_q, wd_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    strobes_t             strobes;
    logic                 load_use;

    load_use_detect u_load_use_detect (
        .ex_mem_read (inExMemRead),
        .ex_dest     (inExDestRegister),
        .id_rs       (inIdRs),
        .id_rt       (inIdRt),
        .id_uses_rt  (inIdUsesRt),
        .hazard      (load_use)
    );

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        strobes   = STROBES_RUN;
        state_d   = state_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;

        if (inMemWait) begin
            strobes = STROBES_FREEZE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (inExBranchTaken) begin
                        strobes = STROBES_FLUSH;
                        state_d = ST_FLUSH;
                    end else if (inExMulDivStart) begin
                        state_d = ST_MULDIV;
                        wd_d    = '0;
                    end else if (load_use) begin
                        strobes = STROBES_LOAD_USE;
                    end
                end
                ST_FLUSH: begin
                    strobes = STROBES_FLUSH;
                    state_d = ST_RUN;
                end
                ST_MULDIV: begin
                    strobes = STROBES_FREEZE;
                    wd_d    = wd_q + 1'b1;
                    if (inMulDivDone) begin
                        // Result is ready: release EX now so it retires this cycle.
                        strobes.ex_hold = 1'b0;
                        state_d         = ST_RUN;
                    end else if (wd_q == WD_LAST) begin
                        state_d   = ST_RUN;
                        timeout_d = 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        // The pipeline must see plain RUN strobes for as long as reset is held.
        if (!reset) begin
            strobes = STROBES_RUN;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!strobes.pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wd_q        <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign outPcWrite    = strobes.pc_write;
    assign outIfIdWrite  = strobes.if_id_write;
    assign outStall      = strobes.stall;
    assign outFlush      = strobes.flush;
    assign outExHold     = strobes.ex_hold;
    assign outTimeout    = timeout_q;
    assign outState      = state_q;
    assign outStallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: the stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the selected DUT.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst_a, rst_b;
    logic [4:0] id_rs, id_rt, ex_dest;
    logic       id_uses_rt, ex_mem_read, br_taken, md_start, md_done, mem_wait;

    logic       a_pc, a_ifid, a_stall, a_flush, a_hold, a_to;
    logic [1:0] a_state;
    logic [3:0] a_cnt;
    logic       b_pc, b_ifid, b_stall, b_flush, b_hold, b_to;
    logic [1:0] b_state;
    logic [15:0] b_cnt;

    // Small watchdog and counter so timeout and saturation are reachable quickly.
    pipeline_hazard_ctrl #(.MULDIV_MAX_CYCLES(4), .CNT_WIDTH(4)) u_dut_a (
        .clk(clk), .reset(rst_a),
        .inIdRs(id_rs), .inIdRt(id_rt), .inIdUsesRt(id_uses_rt),
        .inExMemRead(ex_mem_read), .inExDestRegister(ex_dest),
        .inExBranchTaken(br_taken), .inExMulDivStart(md_start),
        .inMulDivDone(md_done), .inMemWait(mem_wait),
        .outPcWrite(a_pc), .outIfIdWrite(a_ifid), .outStall(a_stall),
        .outFlush(a_flush), .outExHold(a_hold), .outTimeout(a_to),
        .outState(a_state), .outStallCount(a_cnt)
    );

    // Default parameters: long enough watchdog for a 5-cycle mul/div.
    pipeline_hazard_ctrl u_dut_b (
        .clk(clk), .reset(rst_b),
        .inIdRs(id_rs), .inIdRt(id_rt), .inIdUsesRt(id_uses_rt),
        .inExMemRead(ex_mem_read), .inExDestRegister(ex_dest),
        .inExBranchTaken(br_taken), .inExMulDivStart(md_start),
        .inMulDivDone(md_done), .inMemWait(mem_wait),
        .outPcWrite(b_pc), .outIfIdWrite(b_ifid), .outStall(b_stall),
        .outFlush(b_flush), .outExHold(b_hold), .outTimeout(b_to),
        .outState(b_state), .outStallCount(b_cnt)
    );

    typedef struct {
        string       name;
        bit          sel_b;
        logic [23:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc, ifid, stall, flush, hold, timeout, state[1:0], count[15:0]}
    function automatic logic [23:0] ev(bit pc, bit ifid, bit st, bit fl, bit hd,
                                       bit to, logic [1:0] s, int cnt);
        return {pc, ifid, st, fl, hd, to, s, 16'(cnt)};
    endfunction

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (pc,ifid,stall,flush,hold,to,state | count)",
                     name, got, exp);
        end
    endtask

    task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mr, input logic [4:0] dest, input logic br,
                       input logic mds, input logic done, input logic mw);
        id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_mem_read = mr; ex_dest = dest;
        br_taken = br; md_start = mds; md_done = done; mem_wait = mw;
    endtask

    task automatic clr();
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cyc(input string name, input bit sel_b, input logic [23:0] exp);
        exp_t e;
        e.name = name; e.sel_b = sel_b; e.exp = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare once per cycle, half a period after inputs settle.
    initial begin
        exp_t        e;
        logic [23:0] obs;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.sel_b)
                    obs = {b_pc, b_ifid, b_stall, b_flush, b_hold, b_to, b_state, b_cnt};
                else
                    obs = {a_pc, a_ifid, a_stall, a_flush, a_hold, a_to, a_state, 12'd0, a_cnt};
                check(e.name, obs, e.exp);
            end
        end
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        clr();
        @(posedge clk);
        #1;

        // Reset gating: events present but outputs stay at RUN idle.
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("rst_idle", 0, ev(1,1,0,0,0,0,2'd0,0));
        clr(); rst_a = 1'b1;
        cyc("run_idle", 0, ev(1,1,0,0,0,0,2'd0,0));

        // Load-use on rs, then release.
        drv(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_rs", 0, ev(0,0,1,0,0,0,2'd0,0));
        drv(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_release", 0, ev(1,1,0,0,0,0,2'd0,1));
        drv(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_rt", 0, ev(0,0,1,0,0,0,2'd0,1));

        // x0 destination and unused rs2 never stall.
        drv(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("x0_masked", 0, ev(1,1,0,0,0,0,2'd0,2));
        drv(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rt_masked", 0, ev(1,1,0,0,0,0,2'd0,2));

        // Branch together with a load-use match: flush wins, state 0,2,0.
        drv(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("br_hazard", 0, ev(1,1,0,1,0,0,2'd0,2));
        cyc("br_flush", 0, ev(1,1,0,1,0,0,2'd2,2));
        clr();
        cyc("br_back", 0, ev(1,1,0,0,0,0,2'd0,2));

        // Watchdog (limit 4), mul/div start outranks a concurrent load-use.
        drv(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("wd_start", 0, ev(1,1,0,0,0,0,2'd0,2));
        clr();
        for (int i = 0; i < 4; i++)
            cyc($sformatf("wd_hold%0d", i + 1), 0, ev(0,0,0,0,1,0,2'd1,2 + i));
        cyc("wd_exit", 0, ev(1,1,0,0,0,1,2'd0,6));
        cyc("wd_sticky", 0, ev(1,1,0,0,0,1,2'd0,6));

        // MemWait in MULDIV freezes the watchdog for 3 cycles.
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("mw_start", 0, ev(1,1,0,0,0,1,2'd0,6));
        clr();
        cyc("mw_md1", 0, ev(0,0,0,0,1,1,2'd1,6));
        cyc("mw_md2", 0, ev(0,0,0,0,1,1,2'd1,7));
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++)
            cyc($sformatf("mw_wait%0d", i + 1), 0, ev(0,0,0,0,1,1,2'd1,8 + i));
        mem_wait = 1'b0;
        cyc("mw_md3", 0, ev(0,0,0,0,1,1,2'd1,11));
        cyc("mw_md4", 0, ev(0,0,0,0,1,1,2'd1,12));
        cyc("mw_run", 0, ev(1,1,0,0,0,1,2'd0,13));

        // MemWait in RUN outranks a taken branch.
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("mw_branch", 0, ev(0,0,0,0,1,1,2'd0,13));
        clr();
        cyc("mw_after", 0, ev(1,1,0,0,0,1,2'd0,14));

        // Stall counter saturates at all-ones.
        drv(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("sat_14", 0, ev(0,0,1,0,0,1,2'd0,14));
        cyc("sat_15", 0, ev(0,0,1,0,0,1,2'd0,15));
        cyc("sat_hold", 0, ev(0,0,1,0,0,1,2'd0,15));
        clr();
        cyc("sat_idle", 0, ev(1,1,0,0,0,1,2'd0,15));

        // Reset mid-MULDIV, then mid-FLUSH.
        md_start = 1'b1;
        cyc("rm_start", 0, ev(1,1,0,0,0,1,2'd0,15));
        clr();
        cyc("rm_md", 0, ev(0,0,0,0,1,1,2'd1,15));
        rst_a = 1'b0; mem_wait = 1'b1;
        cyc("rm_reset", 0, ev(1,1,0,0,0,0,2'd0,0));
        clr(); rst_a = 1'b1;
        cyc("rm_after", 0, ev(1,1,0,0,0,0,2'd0,0));
        br_taken = 1'b1;
        cyc("rf_branch", 0, ev(1,1,0,1,0,0,2'd0,0));
        clr(); rst_a = 1'b0;
        cyc("rf_reset", 0, ev(1,1,0,0,0,0,2'd0,0));
        rst_a = 1'b1;
        cyc("rf_after", 0, ev(1,1,0,0,0,0,2'd0,0));

        // Default-parameter instance: start at cycle 0, done at cycle 5.
        rst_b = 1'b1;
        cyc("b_idle", 1, ev(1,1,0,0,0,0,2'd0,0));
        md_start = 1'b1;
        cyc("b_start", 1, ev(1,1,0,0,0,0,2'd0,0));
        clr();
        for (int i = 0; i < 4; i++)
            cyc($sformatf("b_hold%0d", i + 1), 1, ev(0,0,0,0,1,0,2'd1,i));
        md_done = 1'b1;
        cyc("b_done", 1, ev(0,0,0,0,0,0,2'd1,4));
        clr();
        cyc("b_run", 1, ev(1,1,0,0,0,0,2'd0,5));

        for (int i = 0; i < 10 && sb_q.size() > 0; i++)
            @(negedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
